// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Hazard and forwarding controller for a 5-stage RV32IM pipeline, placed beside ID.
//   It tracks in-flight destinations in a two-entry shadow scoreboard (EX and MEM slots),
//   computes forward selects, handles load-use stalls and branch flushes, and counts
//   stall/flush cycles in saturating counters.
//   Optional feature macro: HAZARD_STORE_FWD_EN. When it is defined, store data that depends
//   on a load in EX is forwarded from MEM instead of stalling.

`ifndef SYNTHESIS
// Simulation-only watchdog: a load-use detect while already retrying a stall is illegal.
module hazard_control_unit_chk (
    input logic clk,
    input logic rst,
    input logic in_luse,
    input logic load_use
);
    // Flag a second back-to-back load-use stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(in_luse && load_use))
                else $error("hazard_control_unit: illegal double load-use stall");
        end
    end
endmodule
`endif

module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      ID_Instruction,
    input  logic             ID_Valid,
    input  logic             ID_Write_Enable,
    input  logic             ID_Mem_Read,
    input  logic             Branch_Taken,
    output logic             STALL,
    output logic             BUBBLE,
    output logic             FLUSH_IF_ID,
    output logic [1:0]       Load_Use_Hazard_RS1,
    output logic [1:0]       Load_Use_Hazard_RS2,
    output logic             FORWARD_MEMORY,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LUSE  = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, we: 1'b0, load: 1'b0};

    state_t           state_q, state_d;
    slot_t            ex_slot_q, ex_slot_d;
    slot_t            mem_slot_q, mem_slot_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic [4:0] rd_s, rs1_s, rs2_s;
    logic [6:0] opcode_s;
    logic       rs1_used_s, rs2_used_s, is_store_s;
    logic       ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
    logic       lu1_s, lu2_s, store_fwd_s, load_use_s;
    logic       unused_s;

    // An entry matches a source when it is a live writer of that non-zero register.
    function automatic logic slot_hit(input slot_t slot, input logic [4:0] rs, input logic used);
        return used && slot.valid && slot.we && (slot.rd == rs) && (rs != 5'd0);
    endfunction

    // Forward select for one source; EX wins over MEM, a load in EX never forwards.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_load, input logic mem_hit);
        if (ex_hit) begin
            return ex_load ? SEL_RF : SEL_EX;
        end else if (mem_hit) begin
            return SEL_MEM;
        end else begin
            return SEL_RF;
        end
    endfunction

    assign rd_s     = ID_Instruction[11:7];
    assign rs1_s    = ID_Instruction[19:15];
    assign rs2_s    = ID_Instruction[24:20];
    assign opcode_s = ID_Instruction[6:0];
    assign unused_s = ^{ID_Instruction[31:25], ID_Instruction[14:12]};

    // Decode which source registers the ID instruction actually reads.
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        is_store_s = (opcode_s == OP_S);
        case (opcode_s)
            OP_LUI, OP_AUIPC, OP_JAL: rs1_used_s = 1'b0;
            default:                  rs1_used_s = 1'b1;
        endcase
        case (opcode_s)
            OP_R, OP_S, OP_B: rs2_used_s = 1'b1;
            default:          rs2_used_s = 1'b0;
        endcase
    end

    // Scoreboard matching and load-use detection.
    always_comb begin
        ex_hit1_s  = slot_hit(ex_slot_q, rs1_s, rs1_used_s);
        ex_hit2_s  = slot_hit(ex_slot_q, rs2_s, rs2_used_s);
        mem_hit1_s = slot_hit(mem_slot_q, rs1_s, rs1_used_s);
        mem_hit2_s = slot_hit(mem_slot_q, rs2_s, rs2_used_s);
        lu1_s      = ex_hit1_s && ex_slot_q.load;
        lu2_s      = ex_hit2_s && ex_slot_q.load;
`ifdef HAZARD_STORE_FWD_EN
        store_fwd_s = is_store_s && lu2_s && !lu1_s;
`else
        store_fwd_s = 1'b0;
`endif
        load_use_s = ID_Valid && !Branch_Taken && !Reset && (lu1_s || (lu2_s && !store_fwd_s));
    end

    // Mealy pipeline-control outputs; reset, then branch flush, take precedence.
    always_comb begin
        STALL               = 1'b0;
        BUBBLE              = 1'b0;
        FLUSH_IF_ID         = 1'b0;
        Load_Use_Hazard_RS1 = SEL_RF;
        Load_Use_Hazard_RS2 = SEL_RF;
        FORWARD_MEMORY      = 1'b0;
        if (Reset) begin
            BUBBLE      = 1'b1;
            FLUSH_IF_ID = 1'b1;
        end else if (Branch_Taken) begin
            BUBBLE      = 1'b1;
            FLUSH_IF_ID = 1'b1;
        end else if (!ID_Valid) begin
            BUBBLE = 1'b0;
        end else if (load_use_s) begin
            STALL  = 1'b1;
            BUBBLE = 1'b1;
        end else begin
            Load_Use_Hazard_RS1 = fwd_sel(ex_hit1_s, ex_slot_q.load, mem_hit1_s);
            Load_Use_Hazard_RS2 = store_fwd_s ? SEL_RF
                                              : fwd_sel(ex_hit2_s, ex_slot_q.load, mem_hit2_s);
            FORWARD_MEMORY      = store_fwd_s && is_store_s;
        end
    end

    // Scoreboard advance: the ID instruction enters EX unless a bubble is inserted.
    always_comb begin
        mem_slot_d = ex_slot_q;
        if (BUBBLE) begin
            ex_slot_d = SLOT_EMPTY;
        end else begin
            ex_slot_d = '{valid: ID_Valid, rd: rd_s, we: ID_Write_Enable, load: ID_Mem_Read};
        end
    end

    // Next-state logic for the stall/flush tracking FSM.
    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (Branch_Taken) begin
                    state_d = ST_FLUSH;
                end else if (load_use_s) begin
                    state_d = ST_LUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LUSE, ST_FLUSH: begin
                if (Branch_Taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Saturating performance counters, stepped on edges spent in LUSE / FLUSH.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((state_q == ST_LUSE) && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
        if ((state_q == ST_FLUSH) && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // State, scoreboard and counter registers with asynchronous reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_RUN;
            ex_slot_q     <= SLOT_EMPTY;
            mem_slot_q    <= SLOT_EMPTY;
            stall_count_q <= CNT_ZERO;
            flush_count_q <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            ex_slot_q     <= ex_slot_d;
            mem_slot_q    <= mem_slot_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign Stall_Count = stall_count_q;
    assign Flush_Count = flush_count_q;

`ifndef SYNTHESIS
    hazard_control_unit_chk u_chk (
        .clk      (CLK),
        .rst      (Reset),
        .in_luse  (state_q == ST_LUSE),
        .load_use (load_use_s)
    );
`endif

endmodule
